// File: rtl/hazard_flush_ctrl.sv
// Load-use / branch / mul-div hazard controller for the 16-bit pipeline.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_flush_ctrl #(
  parameter int unsigned REG_AW        = 4,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IDEX_MemRead,
  input  logic [REG_AW-1:0] IDEX_RT,
  input  logic [REG_AW-1:0] IFID_RS,
  input  logic [REG_AW-1:0] IFID_RT,
  input  logic              IFID_uses_RT,
  input  logic              branch_taken,
  input  logic              muldiv_start,
  output logic              PC_write,
  output logic              IFID_write,
  output logic              IFID_FLUSH,
  output logic              IDEX_FLUSH,
  output logic              EX_hold,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_events
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MULDIV     = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  // R0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = IDEX_MemRead && (IDEX_RT != '0) &&
                    ((IDEX_RT == IFID_RS) || (IFID_uses_RT && (IDEX_RT == IFID_RT)));

  // Next-state and combinational pipeline controls.
  always_comb begin
    PC_write   = 1'b1;
    IFID_write = 1'b1;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    EX_hold    = 1'b0;
    state_nxt  = state;
    cnt_nxt    = cnt;
    if (reset) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
      state_nxt  = RUN;
      cnt_nxt    = '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
          end else if (muldiv_start) begin
            EX_hold    = 1'b1;
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            cnt_nxt    = CNT_W'(MULDIV_CYCLES - 1);
            state_nxt  = MULDIV;
          end else if (load_use) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_FLUSH = 1'b1;
            state_nxt  = LOAD_STALL;
          end
        end
        LOAD_STALL: begin
          // Load-use masked here; a taken branch still squashes IF/ID and ID/EX.
          if (branch_taken) begin
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
          end
          state_nxt = RUN;
        end
        MULDIV: begin
          EX_hold    = 1'b1;
          PC_write   = 1'b0;
          IFID_write = 1'b0;
          if (cnt == CNT_W'(1)) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!PC_write && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if ((IFID_FLUSH || IDEX_FLUSH) && (flush_events != 16'hFFFF))
        flush_events <= flush_events + 16'd1;
    end
  end
`else
  assign stall_cycles = 16'h0000;
  assign flush_events = 16'h0000;
`endif

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline hazard controller for the 16-bit pipelined core; it is the driver end of the ID/EX buffer's IDEX_FLUSH input.
- Watches the instruction in EX and the instruction in ID, then generates PC/IF-ID write enables, IF/ID and ID/EX flushes, and an EX hold.
- Sequences three events: load-use stalls, taken-branch flushes, and multi-cycle mul/div holds.

Parameters:
- REG_AW, 4, register-address width (16 registers).
- MULDIV_CYCLES, 4, total EX hold cycles for a mul/div instruction; legal range 2..255.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_RT  in  REG_AW  destination register of the instruction in EX.
- IFID_RS  in  REG_AW  source register 1 of the instruction in ID.
- IFID_RT  in  REG_AW  source register 2 of the instruction in ID.
- IFID_uses_RT  in  1  ID instruction reads IFID_RT.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- muldiv_start  in  1  EX instruction is a multi-cycle mul/div, first EX cycle.
- PC_write  out  1  PC update enable.
- IFID_write  out  1  IF/ID buffer load enable.
- IFID_FLUSH  out  1  clear IF/ID.
- IDEX_FLUSH  out  1  zero ID/EX control fields (insert bubble).
- EX_hold  out  1  freeze ID/EX and EX stage contents.
- stall_cycles  out  16  performance counter (see Optional Feature).
- flush_events  out  16  performance counter (see Optional Feature).

Behaviour:
- States: RUN, LOAD_STALL, MULDIV. State and counter cnt[7:0] are registered. Outputs are combinational from current state, cnt and inputs.
- While reset=1:
  - PC_write=0, IFID_write=0, IFID_FLUSH=1, IDEX_FLUSH=1, EX_hold=0.
  - Next state is RUN, cnt=0.
  - Reset wins over every event, including mid-MULDIV.
- RUN, default (no event): PC_write=1, IFID_write=1, all flushes 0, EX_hold=0.
- RUN event priority: branch_taken > muldiv_start > load-use. Only the highest-priority event acts.
- Branch in RUN:
  - IFID_FLUSH=1, IDEX_FLUSH=1, PC_write=1 (target loads), IFID_write=1.
  - Next state RUN. Exactly 1 cycle; 2 squashed instructions.
- Mul/div in RUN:
  - EX_hold=1, PC_write=0, IFID_write=0, flushes 0.
  - cnt <= MULDIV_CYCLES-1; next state MULDIV.
- MULDIV:
  - EX_hold=1, PC_write=0, IFID_write=0, flushes 0.
  - If cnt==1, next state RUN; else cnt <= cnt-1.
  - Total hold is exactly MULDIV_CYCLES cycles, counting the start cycle.
  - branch_taken and muldiv_start are ignored in MULDIV because EX is frozen.
- Load-use condition: IDEX_MemRead=1 AND IDEX_RT != 0 AND (IDEX_RT==IFID_RS OR (IFID_uses_RT AND IDEX_RT==IFID_RT)).
  - R0 never triggers a stall.
- Load-use in RUN:
  - PC_write=0, IFID_write=0, IDEX_FLUSH=1 (one bubble).
  - Next state LOAD_STALL.
- LOAD_STALL:
  - PC_write=1, IFID_write=1, flushes 0; load-use detection is masked.
  - branch_taken is still honoured with RUN branch outputs.
  - Next state RUN. Exactly one bubble per load-use.
- Back-to-back loads that each hit the following instruction stall once per load. RUN is re-entered between them.
- No outputs are X after the first reset cycle.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments every cycle PC_write=0 with reset=0.
  - flush_events increments every cycle IFID_FLUSH=1 or IDEX_FLUSH=1 with reset=0.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: both ports are tied to 16'h0000 and no counter flops exist.
- Ports are present in both builds so fixtures are unchanged.

Test Plan:
- Reset: hold reset=1 for 2 cycles -> IFID_FLUSH=1, IDEX_FLUSH=1, PC_write=0. After release with no events -> PC_write=1, IFID_write=1, flushes 0.
- Load-use: IDEX_MemRead=1, IDEX_RT=4, IFID_RS=4 -> one cycle of PC_write=0, IFID_write=0, IDEX_FLUSH=1, then a LOAD_STALL cycle with PC_write=1. Repeat with IDEX_RT=0 -> no stall.
- RT path: IDEX_MemRead=1, IDEX_RT=7, IFID_RS=3, IFID_RT=7. With IFID_uses_RT=0 -> no stall. With IFID_uses_RT=1 -> one stall.
- Branch: branch_taken=1 for one cycle in RUN -> IFID_FLUSH=1, IDEX_FLUSH=1, PC_write=1 that cycle only. Branch_taken=1 coincident with load-use -> branch outputs only, no stall.
- Mul/div: muldiv_start=1 with MULDIV_CYCLES=4 -> EX_hold=1 for exactly 4 cycles, then RUN. Branch_taken pulsed in cycle 3 -> ignored. Reset asserted in cycle 2 -> immediate reset outputs, RUN afterward.
- Counters (HAZARD_PERF_CNT_EN): after 1 load-use stall, 1 branch and 1 mul/div of 4 cycles -> stall_cycles=5, flush_events=2. Without the macro -> both 0.
